// File: rtl/fwft_fifo_ctrl.sv
// rtl/fwft_fifo_ctrl.sv - first-word-fall-through FIFO with head register, thresholds and flush
// Optional sticky OVERFLOW/UNDERFLOW flags are built only when FWFT_FIFO_ERR_EN is defined.
module fwft_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       FLUSH,
    input  logic                       WR_ENB,
    input  logic [WIDTH-1:0]           DATA_IN,
    output logic                       FULL,
    output logic                       ALMOST_FULL,
    input  logic                       RD_ENB,
    output logic [WIDTH-1:0]           DATA_OUT,
    output logic                       EMPTY,
    output logic                       ALMOST_EMPTY,
    output logic [$clog2(DEPTH+1)-1:0] COUNT,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AF    = CW'(AF_THRESH);
    localparam logic [CW-1:0] LP_AE    = CW'(AE_THRESH);

    // The buffer has DEPTH slots but never holds more than DEPTH-1 words
    // (the head register holds one), so equal pointers always mean empty.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_hv;
    logic             r_empty;
    logic             r_full;
    logic             r_af;
    logic             r_ae;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_buf_empty;
    logic          w_head_load;
    logic          w_bypass;
    logic          w_buf_wr;
    logic          w_buf_rd;
    logic          w_hv_nxt;
    logic [CW-1:0] w_count_nxt;

    always_comb begin
        w_wr_acc    = WR_ENB & ~r_full;
        w_rd_acc    = RD_ENB & ~r_empty;
        w_buf_empty = (r_wr_ptr == r_rd_ptr);
        w_head_load = ~r_hv | w_rd_acc;
        w_bypass    = w_head_load & w_buf_empty & w_wr_acc;
        w_buf_wr    = w_wr_acc & ~w_bypass;
        w_buf_rd    = w_head_load & ~w_buf_empty;
        w_hv_nxt    = w_head_load ? (~w_buf_empty | w_wr_acc) : r_hv;
        w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
    end

    always_ff @(posedge CLK) begin
        if (w_buf_wr && !FLUSH) begin
            r_mem[r_wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_hv     <= 1'b0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else if (FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hv     <= 1'b0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            if (w_buf_rd) begin
                r_head   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else if (w_bypass) begin
                r_head <= DATA_IN;
            end
            if (w_buf_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            r_hv    <= w_hv_nxt;
            r_count <= w_count_nxt;
            r_empty <= ~w_hv_nxt;
            r_full  <= (w_count_nxt == LP_DEPTH);
            r_af    <= (w_count_nxt >= LP_AF);
            r_ae    <= (w_count_nxt <= LP_AE);
        end
    end

`ifdef FWFT_FIFO_ERR_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (FLUSH) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (WR_ENB & r_full);
            r_unf <= r_unf | (RD_ENB & r_empty);
        end
    end

    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_unf;
`else
    assign OVERFLOW  = 1'b0;
    assign UNDERFLOW = 1'b0;
`endif

    assign DATA_OUT     = r_head;
    assign EMPTY        = r_empty;
    assign FULL         = r_full;
    assign ALMOST_FULL  = r_af;
    assign ALMOST_EMPTY = r_ae;
    assign COUNT        = r_count;
endmodule
